rc_receiver_multi: RTL and testbench
====================================

// Module: rc_receiver_multi
// PURPOSE
//  Parametrised N-channel RC receiver front end: measures the high time of each PWM input in us_clk
//  cycles, clamps and scales it to a REC_VAL_BIT_WIDTH value. Adds glitch rejection, per-channel
//  signal-loss timeout and failsafe substitution, which the fixed 7-channel receiver does not have.
//  Sits between the RC receiver pins and angle_controller/motor path in drone2.
// PARAMETERS
//  NUM_CH        4             number of PWM channels
//  VAL_W         8             output value width per channel (REC_VAL_BIT_WIDTH)
//  CNT_W         16            pulse/timeout counter width; counters saturate at 2^CNT_W-1
//  MIN_US        1000          pulse width mapped to value 0
//  MAX_US        2000          clamp ceiling for pulse width
//  SHIFT         2             value = (clamp(width)-MIN_US) >> SHIFT, saturated to 2^VAL_W-1
//  GLITCH_MIN_US 800           accepted pulses are >= GLITCH_MIN_US cycles
//  GLITCH_MAX_US 2500          accepted pulses are <= GLITCH_MAX_US cycles
//  TIMEOUT_US    25000         cycles without an accepted pulse before a channel is lost
//  FAILSAFE_VALS 32'h7D7D7D00  packed NUM_CH*VAL_W, ch0 in LSBs; value forced while lost
// PORTS
//  us_clk          in   1             1 MHz clock; only clock in the block
//  resetn          in   1             synchronous, active-low reset
//  pwm_in          in   NUM_CH        raw asynchronous PWM inputs, bit i = channel i
//  ch_vals         out  NUM_CH*VAL_W  packed channel values, ch0 in LSBs
//  ch_valid_strobe out  NUM_CH        1-cycle pulse when the channel's value updates from an accepted pulse
//  ch_lost         out  NUM_CH        1 = channel has no valid signal
//  any_lost        out  1             registered OR of ch_lost
// BEHAVIOUR
//  - Interface: one clock us_clk; reset resetn is synchronous and active-low.
//  - Reset (resetn low at a us_clk edge): ch_vals=FAILSAFE_VALS, ch_valid_strobe=0, ch_lost=all 1,
//    any_lost=1, counters 0, armed=0. Reset mid-pulse discards the pulse in progress.
//  - Input path per channel: 2-flop synchroniser, then edge detect (sync vs previous sync).
//  - Rising edge: width counter loads 1, armed=1. While sync high: width += 1, saturating.
//  - Falling edge with armed=1: width = cycles sync was high. Accepted iff
//    GLITCH_MIN_US <= width <= GLITCH_MAX_US. Falling edge with armed=0 (post-reset partial pulse) is ignored.
//  - Accept: w=min(max(width,MIN_US),MAX_US); val=min((w-MIN_US)>>SHIFT, 2^VAL_W-1). On the next edge:
//    ch_vals slice=val, strobe=1 for exactly 1 cycle, ch_lost=0, timeout counter=0.
//    Latency: strobe goes high on the 4th us_clk edge after the first edge sampling pwm_in low.
//  - Reject: ch_vals holds, no strobe, timeout counter keeps running; armed cleared.
//  - Timeout counter increments every cycle (saturating); when it reaches TIMEOUT_US: ch_lost=1 and
//    ch_vals slice=FAILSAFE slice; stays lost until the next accepted pulse. Stuck-high input times out too.
//  - Accept and timeout in the same cycle: accept wins, counter cleared, ch_lost=0.
//  - Channels fully independent; simultaneous events on several channels all handled in the same cycle.
//  - any_lost registered from ch_lost: lags ch_lost by one cycle.
// STRUCTURE
//  - Shared constants (MIN_US, MAX_US, TIMEOUT_US, default failsafe values, REC_VAL_BIT_WIDTH) go in
//    common_defines.v as `defines; this module's parameters default to them.
//  - One sub-module rc_pwm_channel (sync, edge detect, width/timeout counters, accept/scale, lost flag),
//    instantiated NUM_CH times by a generate loop; top level packs outputs and forms any_lost.
// TESTING (NUM_CH=4, defaults)
//  1. ch0 high 1500 cycles -> ch_vals[7:0]=125, ch_valid_strobe[0] high 1 cycle, ch_lost[0]=0, others unchanged.
//  2. ch1 widths 2100 / 950 / 3000 / 700 -> 250 / 0 / held 0 no strobe / held 0 no strobe.
//  3. ch2 valid pulse, then pwm_in low 25000 cycles -> ch_lost[2]=1 exactly at count 25000, ch_vals[23:16]=8'h7D,
//     any_lost=1 a cycle later; next 1000-cycle pulse -> value 0, ch_lost[2]=0.
//  4. All 4 channels fall on same cycle, widths 1000/1250/1750/2000 -> 0/62/187/250, all 4 strobes same cycle.
//  5. resetn low 1 cycle in middle of a 1500 ch3 pulse -> reset values; that falling edge ignored; next 1500 -> 125.
//  6. ch0 held high 30000 cycles -> ch_lost[0]=1, ch_vals[7:0]=0, no strobe on eventual falling edge (width > 2500).

Source files
------------

// File: rtl/rc_receiver_multi_pkg.sv
// Shared constants for the multi-channel RC PWM receiver.
// Parameters in the top and channel modules take their defaults from here.
package rc_receiver_multi_pkg;

  localparam int REC_VAL_BIT_WIDTH = 8;
  localparam int NUM_CH_DEF        = 4;
  localparam int CNT_W_DEF         = 16;
  localparam int MIN_US_DEF        = 1000;
  localparam int MAX_US_DEF        = 2000;
  localparam int SHIFT_DEF         = 2;
  localparam int GLITCH_MIN_DEF    = 800;
  localparam int GLITCH_MAX_DEF    = 2500;
  localparam int TIMEOUT_US_DEF    = 25000;

  localparam logic [31:0] FAILSAFE_DEF = 32'h7D7D7D00;

endpackage

// File: rtl/rc_pwm_channel.sv
// One PWM channel: synchroniser, edge detect, width and timeout counters,
// glitch filter, clamp/scale and lost flag with failsafe value.
module rc_pwm_channel
  import rc_receiver_multi_pkg::*;
#(
  parameter int VAL_W         = REC_VAL_BIT_WIDTH,
  parameter int CNT_W         = CNT_W_DEF,
  parameter int MIN_US        = MIN_US_DEF,
  parameter int MAX_US        = MAX_US_DEF,
  parameter int SHIFT         = SHIFT_DEF,
  parameter int GLITCH_MIN_US = GLITCH_MIN_DEF,
  parameter int GLITCH_MAX_US = GLITCH_MAX_DEF,
  parameter int TIMEOUT_US    = TIMEOUT_US_DEF,
  parameter logic [VAL_W-1:0] FAILSAFE = '0
) (
  input  logic             us_clk,
  input  logic             resetn,
  input  logic             pwm_in,
  output logic [VAL_W-1:0] val,
  output logic             strobe,
  output logic             lost
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_US);
  localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_US);
  localparam logic [CNT_W-1:0] GMIN_C  = CNT_W'(GLITCH_MIN_US);
  localparam logic [CNT_W-1:0] GMAX_C  = CNT_W'(GLITCH_MAX_US);
  localparam logic [CNT_W-1:0] TO_C    = CNT_W'(TIMEOUT_US);
  localparam logic [CNT_W-1:0] VMAX_C  = CNT_W'((1 << VAL_W) - 1);

  logic             s1_q, s2_q, prev_q;
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic             acc_q, acc_d;
  logic [VAL_W-1:0] accv_q, accv_d;
  logic [CNT_W-1:0] to_q, to_d;
  logic [VAL_W-1:0] val_q, val_d;
  logic             strobe_q, strobe_d;
  logic             lost_q, lost_d;

  logic             rise, fall;
  logic [CNT_W-1:0] w_cl, sh;

  assign rise = s2_q & ~prev_q;
  assign fall = ~s2_q & prev_q;

  always_comb begin
    width_d = width_q;
    armed_d = armed_q;
    if (rise) begin
      width_d = CNT_W'(1);
      armed_d = 1'b1;
    end else if (s2_q && width_q != CNT_MAX) begin
      width_d = width_q + CNT_W'(1);
    end
    if (fall) armed_d = 1'b0;

    acc_d = fall & armed_q & (width_q >= GMIN_C) & (width_q <= GMAX_C);

    w_cl = width_q;
    if (width_q < MIN_C) w_cl = MIN_C;
    else if (width_q > MAX_C) w_cl = MAX_C;
    sh = (w_cl - MIN_C) >> SHIFT;
    accv_d = (sh > VMAX_C) ? VMAX_C[VAL_W-1:0] : sh[VAL_W-1:0];
  end

  // An accepted pulse always beats a timeout landing on the same edge.
  always_comb begin
    to_d     = (to_q == CNT_MAX) ? to_q : to_q + CNT_W'(1);
    val_d    = val_q;
    lost_d   = lost_q;
    strobe_d = 1'b0;
    if (acc_q) begin
      val_d    = accv_q;
      strobe_d = 1'b1;
      lost_d   = 1'b0;
      to_d     = '0;
    end else if (to_d >= TO_C) begin
      val_d  = FAILSAFE;
      lost_d = 1'b1;
    end
  end

  // Sync flops reset high so a pulse in flight at reset never re-arms.
  always_ff @(posedge us_clk) begin
    if (!resetn) begin
      s1_q     <= 1'b1;
      s2_q     <= 1'b1;
      prev_q   <= 1'b1;
      armed_q  <= 1'b0;
      width_q  <= '0;
      acc_q    <= 1'b0;
      accv_q   <= '0;
      to_q     <= '0;
      val_q    <= FAILSAFE;
      strobe_q <= 1'b0;
      lost_q   <= 1'b1;
    end else begin
      s1_q     <= pwm_in;
      s2_q     <= s1_q;
      prev_q   <= s2_q;
      armed_q  <= armed_d;
      width_q  <= width_d;
      acc_q    <= acc_d;
      accv_q   <= accv_d;
      to_q     <= to_d;
      val_q    <= val_d;
      strobe_q <= strobe_d;
      lost_q   <= lost_d;
    end
  end

  assign val    = val_q;
  assign strobe = strobe_q;
  assign lost   = lost_q;

endmodule

// File: rtl/rc_receiver_multi.sv
// N-channel RC receiver front end: one rc_pwm_channel per input,
// packed outputs and a registered any-lost flag.
module rc_receiver_multi
  import rc_receiver_multi_pkg::*;
#(
  parameter int NUM_CH        = NUM_CH_DEF,
  parameter int VAL_W         = REC_VAL_BIT_WIDTH,
  parameter int CNT_W         = CNT_W_DEF,
  parameter int MIN_US        = MIN_US_DEF,
  parameter int MAX_US        = MAX_US_DEF,
  parameter int SHIFT         = SHIFT_DEF,
  parameter int GLITCH_MIN_US = GLITCH_MIN_DEF,
  parameter int GLITCH_MAX_US = GLITCH_MAX_DEF,
  parameter int TIMEOUT_US    = TIMEOUT_US_DEF,
  parameter logic [NUM_CH*VAL_W-1:0] FAILSAFE_VALS = FAILSAFE_DEF
) (
  input  logic                    us_clk,
  input  logic                    resetn,
  input  logic [NUM_CH-1:0]       pwm_in,
  output logic [NUM_CH*VAL_W-1:0] ch_vals,
  output logic [NUM_CH-1:0]       ch_valid_strobe,
  output logic [NUM_CH-1:0]       ch_lost,
  output logic                    any_lost
);

  logic any_lost_q, any_lost_d;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    rc_pwm_channel #(
      .VAL_W         (VAL_W),
      .CNT_W         (CNT_W),
      .MIN_US        (MIN_US),
      .MAX_US        (MAX_US),
      .SHIFT         (SHIFT),
      .GLITCH_MIN_US (GLITCH_MIN_US),
      .GLITCH_MAX_US (GLITCH_MAX_US),
      .TIMEOUT_US    (TIMEOUT_US),
      .FAILSAFE      (FAILSAFE_VALS[i*VAL_W +: VAL_W])
    ) u_ch (
      .us_clk (us_clk),
      .resetn (resetn),
      .pwm_in (pwm_in[i]),
      .val    (ch_vals[i*VAL_W +: VAL_W]),
      .strobe (ch_valid_strobe[i]),
      .lost   (ch_lost[i])
    );
  end

  always_comb begin
    any_lost_d = |ch_lost;
  end

  always_ff @(posedge us_clk) begin
    if (!resetn) any_lost_q <= 1'b1;
    else         any_lost_q <= any_lost_d;
  end

  assign any_lost = any_lost_q;

endmodule

// File: tb/tb_rc_receiver_multi.sv
// Directed bench for rc_receiver_multi with default parameters.
// Expected values are hand-computed from pulse widths.
module tb_rc_receiver_multi;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  pwm;
  logic [31:0] ch_vals;
  logic [3:0]  ch_valid_strobe;
  logic [3:0]  ch_lost;
  logic        any_lost;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int s     = 0;
  logic [3:0] seen;

  always #5 clk = ~clk;

  rc_receiver_multi dut (
    .us_clk          (clk),
    .resetn          (resetn),
    .pwm_in          (pwm),
    .ch_vals         (ch_vals),
    .ch_valid_strobe (ch_valid_strobe),
    .ch_lost         (ch_lost),
    .any_lost        (any_lost)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      seen = seen | ch_valid_strobe;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse: w edges sample high, then low; returns right after the drop.
  task automatic pulse(input logic [3:0] m, input int w);
    pwm = pwm | m;
    step(w);
    pwm = pwm & ~m;
  endtask

  // Strobe must be absent for 3 edges, present on the 4th, gone on the 5th.
  task automatic lat(input string tag, input logic [3:0] m);
    step(3);
    chk({tag, "_early"}, 32'(ch_valid_strobe & m), 32'h0);
    step(1);
    chk({tag, "_stb"}, 32'(ch_valid_strobe & m), 32'(m));
  endtask

  initial begin
    resetn = 1'b0;
    pwm    = 4'h0;
    seen   = 4'h0;
    step(2);
    chk("rst_vals", ch_vals, 32'h7D7D7D00);
    chk("rst_lost", 32'(ch_lost), 32'hF);
    chk("rst_stb", 32'(ch_valid_strobe), 32'h0);
    chk("rst_any", 32'(any_lost), 32'h1);
    resetn = 1'b1;
    step(5);

    // 1: ch0 1500 -> 125
    pulse(4'b0001, 1500);
    lat("t1", 4'b0001);
    chk("t1_val", ch_vals, 32'h7D7D7D7D);
    chk("t1_lost", 32'(ch_lost), 32'hE);
    step(1);
    chk("t1_one", 32'(ch_valid_strobe), 32'h0);
    step(10);

    // 2: ch1 2100 / 950 / 3000 / 700
    pulse(4'b0010, 2100);
    lat("t2a", 4'b0010);
    chk("t2a_val", 32'(ch_vals[15:8]), 32'd250);
    chk("t2a_lost", 32'(ch_lost[1]), 32'h0);
    step(10);
    pulse(4'b0010, 950);
    lat("t2b", 4'b0010);
    chk("t2b_val", 32'(ch_vals[15:8]), 32'd0);
    step(10);
    seen = 4'h0;
    pulse(4'b0010, 3000);
    step(10);
    chk("t2c_stb", 32'(seen[1]), 32'h0);
    chk("t2c_val", 32'(ch_vals[15:8]), 32'd0);
    seen = 4'h0;
    pulse(4'b0010, 700);
    step(10);
    chk("t2d_stb", 32'(seen[1]), 32'h0);
    chk("t2d_val", 32'(ch_vals[15:8]), 32'd0);

    // 4: all channels fall together, widths 1000/1250/1750/2000
    pwm = 4'b1000;
    step(250);
    pwm = 4'b1100;
    step(500);
    pwm = 4'b1110;
    step(250);
    pulse(4'b1111, 1000);
    lat("t4", 4'b1111);
    chk("t4_vals", ch_vals, {8'd250, 8'd187, 8'd62, 8'd0});
    chk("t4_lost", 32'(ch_lost), 32'h0);
    step(2);
    chk("t4_any", 32'(any_lost), 32'h0);
    step(10);

    // 3: ch2 timeout, others refreshed afterwards to keep any_lost clean
    pulse(4'b0100, 1500);
    lat("t3a", 4'b0100);
    chk("t3a_val", 32'(ch_vals[23:16]), 32'd125);
    s = cyc;
    step(5);
    pulse(4'b1011, 1500);
    step(10);
    step(s + 24999 - cyc);
    chk("t3_prelost", 32'(ch_lost[2]), 32'h0);
    step(1);
    chk("t3_lost", 32'(ch_lost[2]), 32'h1);
    chk("t3_fs", 32'(ch_vals[23:16]), 32'h7D);
    chk("t3_any_lag", 32'(any_lost), 32'h0);
    step(1);
    chk("t3_any", 32'(any_lost), 32'h1);
    step(5);
    pulse(4'b0100, 1000);
    lat("t3b", 4'b0100);
    chk("t3b_val", 32'(ch_vals[23:16]), 32'd0);
    chk("t3b_lost", 32'(ch_lost[2]), 32'h0);
    step(10);

    // 6: ch0 stuck high
    seen = 4'h0;
    pulse(4'b0001, 30000);
    chk("t6_lost", 32'(ch_lost[0]), 32'h1);
    chk("t6_val", 32'(ch_vals[7:0]), 32'h0);
    step(10);
    chk("t6_stb", 32'(seen[0]), 32'h0);
    chk("t6_still", 32'(ch_lost[0]), 32'h1);

    // 5: reset in the middle of a ch3 pulse
    seen = 4'h0;
    pwm = 4'b1000;
    step(700);
    resetn = 1'b0;
    step(1);
    resetn = 1'b1;
    chk("t5_vals", ch_vals, 32'h7D7D7D00);
    chk("t5_lost", 32'(ch_lost), 32'hF);
    chk("t5_any", 32'(any_lost), 32'h1);
    seen = 4'h0;
    step(799);
    pwm = 4'b0000;
    step(10);
    chk("t5_ign", 32'(seen[3]), 32'h0);
    chk("t5_hold", 32'(ch_vals[31:24]), 32'h7D);
    pulse(4'b1000, 1500);
    lat("t5b", 4'b1000);
    chk("t5b_val", 32'(ch_vals[31:24]), 32'd125);
    chk("t5b_lost", 32'(ch_lost), 32'h7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
